// File: rtl/fp_mul_pipe.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fp_mul_pipe
//
// Three-stage pipelined IEEE-754-format multiplier with valid/ready handshakes.
//   S1: operand decode, special-value classification, full mantissa multiply,
//       biased exponent sum.
//   S2: normalisation (product MSB), round from guard/round/sticky bits,
//       re-normalise on mantissa carry-out.
//   S3: overflow/underflow detection, special-value results, final packing.
// All stages advance together whenever the output register is empty or
// being drained, so bubbles collapse and an unstalled stream runs at one
// result per cycle with a latency of three cycles.
//
// Subnormal inputs are treated as signed zero; results that would be
// subnormal are flushed to signed zero with underflow set.
//
// Optional feature (compile-time macro FP_MUL_EXC_CNT_EN):
//   defined   -> exc_count counts delivered results carrying overflow,
//                underflow or error, saturating at 16'hFFFF.
//   undefined -> exc_count is tied to zero and no counter is built.
//
// Parameters:
//   EXP_W       exponent width (default 8)
//   MAN_W       stored fraction width (default 23); word width is
//               1+EXP_W+MAN_W. MAN_W must be at least 3.
// Ports:
//   clk         clock, all state on the rising edge
//   rst_n       asynchronous active-low reset
//   in_valid    operand valid          in_ready   operand accepted when high
//   a, b        operands               round_mode 00 +inf, 01 -inf,
//                                                 10 nearest-even, 11 ties-away
//   out_valid   result valid           out_ready  downstream accepts result
//   result      product
//   overflow, underflow, inexact, error   status of the presented result
//   exc_count   exception counter (see macro above)
// -----------------------------------------------------------------------------
module fp_mul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  input  logic [1:0]           round_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic                 overflow,
  output logic                 underflow,
  output logic                 inexact,
  output logic                 error,
  output logic [15:0]          exc_count
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int PW   = 2 * (MAN_W + 1);   // full product width
  localparam int EW2  = EXP_W + 2;         // signed working exponent width
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int EMAX = (1 << EXP_W) - 1;

  localparam logic signed [EW2-1:0] BIAS_S  = EW2'(BIAS);
  localparam logic signed [EW2-1:0] EMAX_S  = EW2'(EMAX);
  localparam logic signed [EW2-1:0] EZERO_S = '0;

  typedef enum logic [1:0] {
    CLS_NUM  = 2'd0,   // both operands finite non-zero
    CLS_ZERO = 2'd1,   // signed zero result
    CLS_INF  = 2'd2,   // signed infinity result
    CLS_NAN  = 2'd3    // canonical quiet NaN, error
  } cls_e;

  // ---------------------------------------------------------------------------
  // Pipeline control
  // ---------------------------------------------------------------------------
  logic out_valid_q;
  logic advance;

  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance;

  // ---------------------------------------------------------------------------
  // Stage 1: decode, classify, multiply
  // ---------------------------------------------------------------------------
  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  assign {sa, ea, fa} = a;
  assign {sb, eb, fb} = b;

  assign a_nan  = (&ea) && (|fa);
  assign b_nan  = (&eb) && (|fb);
  assign a_inf  = (&ea) && !(|fa);
  assign b_inf  = (&eb) && !(|fb);
  // A zero exponent covers both true zero and subnormals (flushed to zero).
  assign a_zero = ~|ea;
  assign b_zero = ~|eb;

  cls_e                   s1_cls_d;
  logic                   s1_sign_d;
  logic signed [EW2-1:0]  s1_exp_d;
  logic [PW-1:0]          s1_prod_d;

  always_comb begin
    s1_cls_d = CLS_NUM;
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
      s1_cls_d = CLS_NAN;
    end else if (a_inf || b_inf) begin
      s1_cls_d = CLS_INF;
    end else if (a_zero || b_zero) begin
      s1_cls_d = CLS_ZERO;
    end
  end

  assign s1_sign_d = sa ^ sb;
  assign s1_exp_d  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_S;
  assign s1_prod_d = {{(MAN_W+1){1'b0}}, 1'b1, fa} * {{(MAN_W+1){1'b0}}, 1'b1, fb};

  logic                   s1_valid_q;
  cls_e                   s1_cls_q;
  logic                   s1_sign_q;
  logic signed [EW2-1:0]  s1_exp_q;
  logic [PW-1:0]          s1_prod_q;
  logic [1:0]             s1_mode_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_cls_q   <= CLS_NUM;
      s1_sign_q  <= 1'b0;
      s1_exp_q   <= '0;
      s1_prod_q  <= '0;
      s1_mode_q  <= 2'b00;
    end else if (advance) begin
      s1_valid_q <= in_valid;
      s1_cls_q   <= s1_cls_d;
      s1_sign_q  <= s1_sign_d;
      s1_exp_q   <= s1_exp_d;
      s1_prod_q  <= s1_prod_d;
      s1_mode_q  <= round_mode;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: normalise and round
  // ---------------------------------------------------------------------------
  // The product of two [1,2) mantissas lies in [1,4): when the top bit is set
  // the binary point moves one place left and the exponent gains one.
  logic             hi;
  logic [MAN_W-1:0] frac_pre;
  logic             guard_bit, round_bit, sticky_bit, rnd_inexact;
  logic             round_up, carry;

  assign hi         = s1_prod_q[PW-1];
  assign frac_pre   = hi ? s1_prod_q[PW-2 -: MAN_W] : s1_prod_q[PW-3 -: MAN_W];
  assign guard_bit  = hi ? s1_prod_q[MAN_W]         : s1_prod_q[MAN_W-1];
  assign round_bit  = hi ? s1_prod_q[MAN_W-1]       : s1_prod_q[MAN_W-2];
  assign sticky_bit = hi ? (|s1_prod_q[MAN_W-2:0])  : (|s1_prod_q[MAN_W-3:0]);
  assign rnd_inexact = guard_bit || round_bit || sticky_bit;

  always_comb begin
    round_up = 1'b0;
    case (s1_mode_q)
      2'b00:   round_up = rnd_inexact && !s1_sign_q;
      2'b01:   round_up = rnd_inexact && s1_sign_q;
      2'b10:   round_up = guard_bit && (round_bit || sticky_bit || frac_pre[0]);
      default: round_up = guard_bit;
    endcase
  end

  logic [MAN_W-1:0]      s2_frac_d;
  logic signed [EW2-1:0] s2_exp_d;

  // A carry out of the fraction means the mantissa became 10.000..., i.e. the
  // fraction wraps to zero and the exponent steps up by one.
  assign {carry, s2_frac_d} = {1'b0, frac_pre} + {{MAN_W{1'b0}}, round_up};
  assign s2_exp_d = s1_exp_q + {{(EW2-1){1'b0}}, hi} + {{(EW2-1){1'b0}}, carry};

  logic                   s2_valid_q;
  cls_e                   s2_cls_q;
  logic                   s2_sign_q;
  logic signed [EW2-1:0]  s2_exp_q;
  logic [MAN_W-1:0]       s2_frac_q;
  logic                   s2_inexact_q;
  logic [1:0]             s2_mode_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q   <= 1'b0;
      s2_cls_q     <= CLS_NUM;
      s2_sign_q    <= 1'b0;
      s2_exp_q     <= '0;
      s2_frac_q    <= '0;
      s2_inexact_q <= 1'b0;
      s2_mode_q    <= 2'b00;
    end else if (advance) begin
      s2_valid_q   <= s1_valid_q;
      s2_cls_q     <= s1_cls_q;
      s2_sign_q    <= s1_sign_q;
      s2_exp_q     <= s2_exp_d;
      s2_frac_q    <= s2_frac_d;
      s2_inexact_q <= rnd_inexact;
      s2_mode_q    <= s1_mode_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: exceptions and packing
  // ---------------------------------------------------------------------------
  logic [W-1:0] inf_word, maxf_word, zero_word, qnan_word;

  assign inf_word  = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  assign maxf_word = {s2_sign_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
  assign zero_word = {s2_sign_q, {(W-1){1'b0}}};
  assign qnan_word = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  logic [W-1:0] result_d;
  logic         ovf_d, unf_d, inx_d, err_d;

  always_comb begin
    result_d = '0;
    ovf_d    = 1'b0;
    unf_d    = 1'b0;
    inx_d    = 1'b0;
    err_d    = 1'b0;
    case (s2_cls_q)
      CLS_NAN: begin
        result_d = qnan_word;
        err_d    = 1'b1;
      end
      CLS_INF:  result_d = inf_word;
      CLS_ZERO: result_d = zero_word;
      default: begin
        if (s2_exp_q >= EMAX_S) begin
          ovf_d = 1'b1;
          inx_d = 1'b1;
          // Directed modes saturate to max finite when rounding away from
          // the result's sign; nearest modes always go to infinity.
          case (s2_mode_q)
            2'b00:   result_d = s2_sign_q ? maxf_word : inf_word;
            2'b01:   result_d = s2_sign_q ? inf_word  : maxf_word;
            default: result_d = inf_word;
          endcase
        end else if (s2_exp_q <= EZERO_S) begin
          unf_d    = 1'b1;
          inx_d    = 1'b1;
          result_d = zero_word;
        end else begin
          inx_d    = s2_inexact_q;
          result_d = {s2_sign_q, s2_exp_q[EXP_W-1:0], s2_frac_q};
        end
      end
    endcase
  end

  logic [W-1:0] result_q;
  logic         ovf_q, unf_q, inx_q, err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      inx_q       <= 1'b0;
      err_q       <= 1'b0;
    end else if (advance) begin
      out_valid_q <= s2_valid_q;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      inx_q       <= inx_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign inexact   = inx_q;
  assign error     = err_q;

  // ---------------------------------------------------------------------------
  // Exception counter
  // ---------------------------------------------------------------------------
`ifdef FP_MUL_EXC_CNT_EN
  logic [15:0] exc_cnt_q, exc_cnt_d;

  always_comb begin
    exc_cnt_d = exc_cnt_q;
    if (out_valid_q && out_ready && (ovf_q || unf_q || err_q) &&
        (exc_cnt_q != 16'hFFFF)) begin
      exc_cnt_d = exc_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exc_cnt_q <= 16'd0;
    end else begin
      exc_cnt_q <= exc_cnt_d;
    end
  end

  assign exc_count = exc_cnt_q;
`else
  assign exc_count = 16'd0;
`endif

endmodule

// File: tb/tb_fp_mul_pipe.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_fp_mul_pipe
//
// Bench for fp_mul_pipe at EXP_W=8, MAN_W=23. A reference model computes each
// product with integer arithmetic (exact product, remainder-based rounding);
// expected results are queued on every accepted operand pair and compared in
// order whenever a result is handed over. Directed cases cover the numeric
// corner cases, back-pressure and reset mid-flight; the bulk is randomized.
// -----------------------------------------------------------------------------
module tb_fp_mul_pipe;

`ifdef FP_MUL_EXC_CNT_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a_in, b_in;
  logic [1:0]  mode;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        overflow, underflow, inexact, error;
  logic [15:0] exc_count;

  always #5 clk = ~clk;

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a_in),
    .b          (b_in),
    .round_mode (mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .overflow   (overflow),
    .underflow  (underflow),
    .inexact    (inexact),
    .error      (error),
    .exc_count  (exc_count)
  );

  int checks   = 0;
  int failures = 0;
  int n_txn    = 0;
  int exp_cnt  = 0;
  int ready_mode = 1;          // 0 low, 1 high, 2 random
  logic [35:0] exp_q[$];       // {ovf, unf, inx, err, result}

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: exact integer product, rounding decided by comparing the
  // discarded remainder against one half ulp.
  function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic [1:0] m);
    logic   s;
    int     ex, ey, e, sh;
    longint mx, my, p, q, rem, half;
    logic   inx, up, xnan, ynan, xinf, yinf, xzero, yzero;
    logic [31:0] inf_w, max_w;
    s     = x[31] ^ y[31];
    ex    = int'(x[30:23]);
    ey    = int'(y[30:23]);
    xnan  = (ex == 255) && (x[22:0] != 0);
    ynan  = (ey == 255) && (y[22:0] != 0);
    xinf  = (ex == 255) && (x[22:0] == 0);
    yinf  = (ey == 255) && (y[22:0] == 0);
    xzero = (ex == 0);
    yzero = (ey == 0);
    inf_w = {s, 8'hFF, 23'h0};
    max_w = {s, 8'hFE, 23'h7FFFFF};
    if (xnan || ynan || (xinf && yzero) || (xzero && yinf)) return {4'b0001, 32'h7FC00000};
    if (xinf || yinf) return {4'b0000, inf_w};
    if (xzero || yzero) return {4'b0000, s, 31'h0};
    mx = longint'(x[22:0]) + (longint'(1) << 23);
    my = longint'(y[22:0]) + (longint'(1) << 23);
    p  = mx * my;
    e  = ex + ey - 127;
    if (p >= (longint'(1) << 47)) begin
      sh = 24;
      e  = e + 1;
    end else begin
      sh = 23;
    end
    q    = p >> sh;
    rem  = p - (q << sh);
    half = longint'(1) << (sh - 1);
    inx  = (rem != 0);
    case (m)
      2'd0:    up = inx && !s;
      2'd1:    up = inx && s;
      2'd2:    up = (rem > half) || ((rem == half) && q[0]);
      default: up = (rem >= half);
    endcase
    q = q + longint'(up);
    if (q == (longint'(1) << 24)) begin
      q = longint'(1) << 23;
      e = e + 1;
    end
    if (e >= 255) begin
      if (m == 2'd0)      return {4'b1010, s ? max_w : inf_w};
      else if (m == 2'd1) return {4'b1010, s ? inf_w : max_w};
      else                return {4'b1010, inf_w};
    end
    if (e <= 0) return {4'b0110, s, 31'h0};
    return {2'b00, inx, 1'b0, s, 8'(e), q[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    int          c = $urandom_range(0, 9);
    logic        s = 1'($urandom_range(0, 1));
    logic [22:0] f = 23'($urandom);
    logic [7:0]  e;
    case (c)
      0: begin e = 8'd0; if ($urandom_range(0, 1) == 0) f = 23'd0; end
      1: begin e = 8'hFF; f = 23'd0; end
      2: begin e = 8'hFF; f = f | 23'd1; end
      3: e = 8'($urandom_range(190, 254));
      4: e = 8'($urandom_range(1, 70));
      default: e = 8'($urandom_range(90, 165));
    endcase
    return {s, e, f};
  endfunction

  // out_ready driver: the only writer of out_ready.
  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Compare process: sampled on the falling edge, inputs change after rising.
  logic        prev_stall = 1'b0;
  logic [35:0] prev_out   = '0;
  logic [35:0] dut_out;
  assign dut_out = {overflow, underflow, inexact, error, result};

  always @(negedge clk) begin
    logic [35:0] e;
    if (!rst_n) begin
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_outputs", 64'(dut_out), 64'd0);
      check("reset_exc_count", 64'(exc_count), 64'd0);
      exp_q.delete();
      exp_cnt    = 0;
      prev_stall = 1'b0;
    end else begin
      check("exc_count", 64'(exc_count), EXC_EN ? 64'(exp_cnt) : 64'd0);
      check("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
      if (prev_stall) begin
        check("stall_valid_hold", 64'(out_valid), 64'd1);
        check("stall_data_hold", 64'(dut_out), 64'(prev_out));
      end
      if (out_valid)
        check("flags_exclusive", 64'($countones({overflow, underflow, error}) <= 1), 64'd1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL stale_output actual=%h required=no_output", dut_out);
        end else begin
          e = exp_q.pop_front();
          n_txn++;
          $display("txn %0d result=%h flags(o,u,i,e)=%b expected=%h", n_txn, result,
                   {overflow, underflow, inexact, error}, e[31:0]);
          check("result_and_flags", 64'(dut_out), 64'(e));
          if ((e[35] || e[34] || e[32]) && exp_cnt < 65535) exp_cnt++;
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a_in, b_in, mode));
      prev_stall = out_valid && !out_ready;
      prev_out   = dut_out;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [1:0] m);
    int n = 0;
    a_in = x; b_in = y; mode = m; in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 100);
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=in_ready_low required=accept_within_100");
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      step();
      n++;
    end
    check("drain_complete", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a_in = '0; b_in = '0; mode = 2'd0;
    ready_mode = 1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_reset", 64'(in_ready), 64'd1);

    // Hand-computed values that pin the model itself.
    check("model_1p5x2", 64'(model(32'h3FC00000, 32'h40000000, 2'd2)), 64'({4'b0000, 32'h40400000}));
    check("model_ulp_rne", 64'(model(32'h3F800001, 32'h3F800001, 2'd2)), 64'({4'b0010, 32'h3F800002}));
    check("model_ulp_up", 64'(model(32'h3F800001, 32'h3F800001, 2'd0)), 64'({4'b0010, 32'h3F800003}));
    check("model_inf_x_0", 64'(model(32'h7F800000, 32'h00000000, 2'd2)), 64'({4'b0001, 32'h7FC00000}));
    check("model_ovf_rne", 64'(model(32'h7F000000, 32'h40000000, 2'd2)), 64'({4'b1010, 32'h7F800000}));
    check("model_ovf_dn", 64'(model(32'h7F000000, 32'h40000000, 2'd1)), 64'({4'b1010, 32'h7F7FFFFF}));
    check("model_unf", 64'(model(32'h00800000, 32'h3F000000, 2'd2)), 64'({4'b0110, 32'h00000000}));

    // Latency on an empty pipeline: visible exactly three cycles after accept.
    step();
    a_in = 32'h3FC00000; b_in = 32'h40000000; mode = 2'd2; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("latency", 64'(out_valid), 64'(k == 3));
    end
    step();

    // Directed numeric corners.
    send(32'h3F800001, 32'h3F800001, 2'd2);
    send(32'h3F800001, 32'h3F800001, 2'd0);
    send(32'h7F800000, 32'h00000000, 2'd2);
    send(32'h7F000000, 32'h40000000, 2'd2);
    send(32'h7F000000, 32'h40000000, 2'd1);
    send(32'hFF000000, 32'h40000000, 2'd0);
    send(32'h7F7FFFFF, 32'h3F800001, 2'd0);
    send(32'h00800000, 32'h3F800000, 2'd2);
    send(32'h00800000, 32'h3F000000, 2'd2);
    send(32'h00000001, 32'hC0000000, 2'd2);
    send(32'h7FC00001, 32'h3F800000, 2'd3);
    send(32'hFF800000, 32'h40400000, 2'd2);
    send(32'h3FFFFFFF, 32'h3FFFFFFF, 2'd3);
    drain();

    // Back-pressure: four back-to-back operands with out_ready held low.
    ready_mode = 0;
    step();
    fork
      begin
        send(32'h3FC00000, 32'h40000000, 2'd2);
        send(32'h40000000, 32'h40400000, 2'd2);
        send(32'hC0A00000, 32'h3F000000, 2'd2);
        send(32'h41200000, 32'h41200000, 2'd2);
      end
      begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("in_ready_low_when_full", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1 ready_mode = 1;
      end
    join
    drain();

    // Reset with two transactions in flight.
    step();
    send(32'h40000000, 32'h40000000, 2'd2);
    send(32'h40400000, 32'h40400000, 2'd2);
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_midreset", 64'(in_ready), 64'd1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("no_stale_after_reset", 64'(out_valid), 64'd0);
    end
    step();

    // Randomized stream with random back-pressure and gaps.
    ready_mode = 2;
    for (int i = 0; i < 300; i++) begin
      send(rand_op(), rand_op(), 2'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 2)) step();
    end
    ready_mode = 1;
    drain();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_mul_pipe.md
FP_MUL_PIPE -- requirements
Module: fp_mul_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent width.
REQ-002 SHALL have parameter MAN_W, default 23, stored-fraction width; W = 1+EXP_W+MAN_W.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports in_valid input 1, in_ready output 1; operand handshake.
REQ-006 SHALL have ports a, b  input  W  IEEE-754-format operands.
REQ-007 SHALL have port round_mode  input  2  00 toward +inf, 01 toward -inf, 10 nearest-even, 11 nearest ties-away.
REQ-008 SHALL have ports out_valid output 1, out_ready input 1; result handshake.
REQ-009 SHALL have port result  output  W  product.
REQ-010 SHALL have ports overflow, underflow, inexact, error  output  1 each; status per result.
REQ-011 SHALL have port exc_count  output  16  exception counter (see Configuration).

Function
REQ-012 SHALL accept a transaction when in_valid && in_ready; a, b, round_mode captured together.
REQ-013 SHALL be a 3-stage pipeline: S1 decode/classify/mantissa multiply, S2 normalise/round, S3 pack/exceptions; latency exactly 3 cycles with no stall.
REQ-014 SHALL advance all stages together when advance = !out_valid || out_ready; in_ready = advance; stalled stages hold contents.
REQ-015 SHALL keep out_valid, result and status stable while out_valid && !out_ready.
REQ-016 SHALL allow bubbles: empty stages collapse so throughput is one result per cycle when out_ready is high.
REQ-017 SHALL preserve transaction order; no drop, no duplication.
REQ-018 SHALL set sign = sign(a) XOR sign(b) for all non-NaN results.
REQ-019 SHALL compute exponent as Ea+Eb-bias (bias = 2^(EXP_W-1)-1) in EXP_W+2 signed bits, +1 when product MSB set.
REQ-020 SHALL round from full 2*(MAN_W+1)-bit product using guard, round and sticky bits per round_mode; mantissa carry-out re-normalises and increments exponent.
REQ-021 SHALL set inexact=1 whenever any discarded bit is non-zero.
REQ-022 SHALL treat subnormal inputs (E=0, F!=0) as signed zero.
REQ-023 SHALL output canonical quiet NaN {0, all-ones E, MSB-only F} with error=1 when either input is NaN or for inf*0 / 0*inf.
REQ-024 SHALL output signed infinity, overflow=0, error=0 for inf*finite-nonzero or inf*inf.
REQ-025 SHALL output signed zero for zero*finite, all flags 0.
REQ-026 SHALL on rounded exponent >= all-ones set overflow=1, inexact=1; result inf for modes 10/11, inf if rounding toward sign else max finite for modes 00/01.
REQ-027 SHALL on rounded exponent <= 0 flush to signed zero, underflow=1, inexact=1.
REQ-028 SHALL assert at most one of overflow, underflow, error per result.

Reset
REQ-029 SHALL on rst_n low clear all stage valids immediately, out_valid=0, result=0, all flags 0, exc_count=0.
REQ-030 SHALL discard in-flight transactions on reset mid-operation; in_ready=1 first cycle after release.

Configuration
REQ-031 SHALL with FP_MUL_EXC_CNT_EN defined count completed outputs (out_valid && out_ready) having overflow|underflow|error, saturating at 16'hFFFF.
REQ-032 SHALL without FP_MUL_EXC_CNT_EN tie exc_count to 0 and build no counter logic.

Verification (EXP_W=8, MAN_W=23)
REQ-033 SHALL verify 0x3FC00000*0x40000000, mode 10 -> 0x40400000, all flags 0, out_valid exactly 3 cycles after accept.
REQ-034 SHALL verify 0x3F800001*0x3F800001: mode 10 -> 0x3F800002, mode 00 -> 0x3F800003, inexact=1.
REQ-035 SHALL verify 0x7F800000*0x00000000 -> 0x7FC00000, error=1; counter 1 if FP_MUL_EXC_CNT_EN.
REQ-036 SHALL verify 0x7F000000*0x40000000: mode 10 -> 0x7F800000, mode 01 -> 0x7F7FFFFF, overflow=1.
REQ-037 SHALL verify 4 back-to-back inputs with out_ready low 5 cycles: in_ready falls, outputs stable, all 4 results delivered in order.
REQ-038 SHALL verify rst_n pulsed low with 2 transactions in flight: out_valid=0 during reset, no stale output after release.
